cu_wb_sched: RTL and testbench
==============================

// Module: cu_wb_sched
// PURPOSE
//  Issue/write-back scheduler for the compute unit. It accepts one op per cycle from the
//  program sequencer and pulses the enable of the target unit (ALU, multiplier or shifter).
//  It drives the crossbar read/write addresses, reserves the single register-file write
//  port per fixed unit latency, and stalls issue on RAW/WAW hazards or write-port conflicts.
//  Bus-connect writes to the RF are arbitrated into free write-back slots.
// PARAMETERS
//  ADDRESS_WIDTH  4  RF register address width
//  SIGNAL_WIDTH   3  width of ps_xb_w_cuEn one-hot (bit0 ALU, bit1 MUL, bit2 SHF)
//  ALU_LAT        1  cycles from issue accept to ALU result write-back (1..MAX_LAT)
//  MUL_LAT        2  same, multiplier
//  SHF_LAT        1  same, shifter
//  MAX_LAT        4  depth D of write-back reservation table
// PORTS
//  clk           in   1    clock, rising edge
//  reset         in   1    asynchronous, active-low reset
//  iss_vld       in   1    op presented
//  iss_unit      in   2    00 ALU, 01 MUL, 10 SHF, 11 illegal
//  iss_rx_use    in   1    op reads raddx
//  iss_ry_use    in   1    op reads raddy
//  iss_raddx     in   AW   source x address
//  iss_raddy     in   AW   source y address
//  iss_wadd      in   AW   destination address
//  iss_rdy       out  1    op accepted this cycle when iss_vld & iss_rdy
//  iss_err       out  1    illegal unit code accepted (1-cycle pulse, registered)
//  ps_alu_en     out  1    ALU enable, high in accept cycle only
//  ps_mul_en     out  1    multiplier enable, high in accept cycle only
//  ps_shf_en     out  1    shifter enable, high in accept cycle only
//  ps_xb_raddx   out  AW   = iss_raddx (combinational)
//  ps_xb_raddy   out  AW   = iss_raddy (combinational)
//  ps_xb_w_cuEn  out  SW   one-hot write-back source, from slot[0]
//  ps_xb_w_bcEn  out  1    RF write from bus-connect this cycle (= bc_gnt)
//  ps_xb_wadd    out  AW   slot[0].addr if slot[0] valid, else bc_wadd
//  bc_req        in   1    bus-connect requests an RF write
//  bc_wadd       in   AW   bus-connect write address
//  bc_gnt        out  1    bus write performed this cycle
//  busy          out  1    any reservation slot valid
//  stall_cnt     out  16   saturating count of cycles with iss_vld & ~iss_rdy
// BEHAVIOUR
//  - Reservation table slot[0..D-1]: {vld, unit, addr}. slot[0] drives write-back combinationally.
//  - Each edge: slot[k] <= slot[k+1]; slot[D-1] <= empty. On accept of unit with latency L,
//    slot[L-1] <= {1, unit, iss_wadd}. Result is written L cycles after the accept cycle.
//  - Lat(unit): ALU_LAT / MUL_LAT / SHF_LAT. slot[D] reads as empty.
//  - iss_rdy = ~(port_conflict | raw | waw | bc_raw), where
//    - port_conflict: slot[L].vld
//    - raw: a used source matches addr of any valid slot
//    - waw: iss_wadd matches addr of any valid slot
//    - bc_raw: bc_gnt and a used source == bc_wadd
//    iss_rdy does not depend on iss_vld.
//  - Illegal unit 11: always ready, no enable, no slot reserved; iss_err pulses next cycle.
//  - Exactly one ps_*_en is high when a legal op is accepted; otherwise all are low.
//  - bc_gnt = bc_req & ~slot[0].vld & (bc_wadd matches no valid slot). The bus waits while
//    bc_gnt is low; the CU write-back always wins.
//  - ps_xb_w_cuEn = one-hot(slot[0].unit) when slot[0].vld, else 0.
//  - stall_cnt increments on iss_vld & ~iss_rdy and saturates at 16'hFFFF.
//  - Reset low (any time, including mid-flight): all slots cleared, iss_err = 0,
//    stall_cnt = 0. Outputs then read iss_rdy = 1, busy = 0, all enables/cuEn/bcEn = 0.
//    In-flight results are dropped.
//  - Static check: any LAT outside 1..MAX_LAT is a $error at elaboration.
// TESTING
//  1. ALU op wadd=3 at cycle 0 -> ps_alu_en at c0; cuEn=001, wadd=3 at c1; busy=0 at c2.
//  2. MUL wadd=5 at c0, ALU wadd=6 at c1 -> ALU stalled at c1 (slot[1] taken);
//     ALU accepted c2; MUL write-back c2, ALU write-back c3; stall_cnt=1.
//  3. MUL wadd=4 at c0, ALU raddx=4 rx_use=1 at c1 -> iss_rdy=0 at c1-c2;
//     accepted c3 after the c2 write-back.
//  4. bc_req wadd=7 while slot[0] is valid -> bc_gnt=0; bc_gnt=1 and bcEn=1 on the
//     first free cycle; an ALU reading r7 in that cycle stalls.
//  5. iss_unit=11 -> iss_rdy=1, no enable, iss_err=1 next cycle. Reset pulsed with MUL
//     in flight -> cuEn never asserts; busy=0, stall_cnt=0.
//  6. Hold a conflicting iss_vld 70000 cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/cu_wb_sched_if.sv
// cu_wb_sched_if
//   Bundles the issue handshake, crossbar controls and bus-connect write
//   request of the compute-unit write-back scheduler.
//   master : program sequencer / bus-connect side (drives iss_* and bc_req/bc_wadd)
//   slave  : the scheduler (drives ready, unit enables, crossbar and status)
interface cu_wb_sched_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3
);
  logic                     iss_vld;
  logic [1:0]               iss_unit;
  logic                     iss_rx_use;
  logic                     iss_ry_use;
  logic [ADDRESS_WIDTH-1:0] iss_raddx;
  logic [ADDRESS_WIDTH-1:0] iss_raddy;
  logic [ADDRESS_WIDTH-1:0] iss_wadd;
  logic                     iss_rdy;
  logic                     iss_err;
  logic                     ps_alu_en;
  logic                     ps_mul_en;
  logic                     ps_shf_en;
  logic [ADDRESS_WIDTH-1:0] ps_xb_raddx;
  logic [ADDRESS_WIDTH-1:0] ps_xb_raddy;
  logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn;
  logic                     ps_xb_w_bcEn;
  logic [ADDRESS_WIDTH-1:0] ps_xb_wadd;
  logic                     bc_req;
  logic [ADDRESS_WIDTH-1:0] bc_wadd;
  logic                     bc_gnt;
  logic                     busy;
  logic [15:0]              stall_cnt;

  modport master (
    output iss_vld, iss_unit, iss_rx_use, iss_ry_use, iss_raddx, iss_raddy, iss_wadd,
    output bc_req, bc_wadd,
    input  iss_rdy, iss_err, ps_alu_en, ps_mul_en, ps_shf_en,
    input  ps_xb_raddx, ps_xb_raddy, ps_xb_w_cuEn, ps_xb_w_bcEn, ps_xb_wadd,
    input  bc_gnt, busy, stall_cnt
  );

  modport slave (
    input  iss_vld, iss_unit, iss_rx_use, iss_ry_use, iss_raddx, iss_raddy, iss_wadd,
    input  bc_req, bc_wadd,
    output iss_rdy, iss_err, ps_alu_en, ps_mul_en, ps_shf_en,
    output ps_xb_raddx, ps_xb_raddy, ps_xb_w_cuEn, ps_xb_w_bcEn, ps_xb_wadd,
    output bc_gnt, busy, stall_cnt
  );
endinterface

// File: rtl/cu_wb_sched.sv
// cu_wb_sched
//   Issue / write-back scheduler for the compute unit. Accepts one op per
//   cycle, pulses the target unit enable, drives the crossbar addresses and
//   books the single register-file write port in a reservation table indexed
//   by cycles-until-write-back. Issue stalls on RAW/WAW hazards against
//   in-flight results, on write-port conflicts and on a granted bus-connect
//   write to a source register. Bus-connect writes fill free write-back slots.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : cu_wb_sched_if.slave (issue handshake, unit enables, crossbar
//            read/write controls, bus-connect request/grant, busy, stall_cnt)
module cu_wb_sched #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3,
  parameter int ALU_LAT       = 1,
  parameter int MUL_LAT       = 2,
  parameter int SHF_LAT       = 1,
  parameter int MAX_LAT       = 4
) (
  input logic          clk,
  input logic          reset,
  cu_wb_sched_if.slave bus
);

  localparam logic [1:0] UNIT_ALU = 2'b00;
  localparam logic [1:0] UNIT_MUL = 2'b01;
  localparam logic [1:0] UNIT_SHF = 2'b10;

  // Elaboration-time sanity checks on the latency configuration.
  if (ALU_LAT < 1 || ALU_LAT > MAX_LAT) begin : gAluLatBad
    $error("cu_wb_sched: ALU_LAT must lie within 1..MAX_LAT");
  end
  if (MUL_LAT < 1 || MUL_LAT > MAX_LAT) begin : gMulLatBad
    $error("cu_wb_sched: MUL_LAT must lie within 1..MAX_LAT");
  end
  if (SHF_LAT < 1 || SHF_LAT > MAX_LAT) begin : gShfLatBad
    $error("cu_wb_sched: SHF_LAT must lie within 1..MAX_LAT");
  end
  if (SIGNAL_WIDTH < 3) begin : gSigWidthBad
    $error("cu_wb_sched: SIGNAL_WIDTH must be at least 3");
  end

  // Reservation table: entry k holds the result written back k cycles from now.
  logic [MAX_LAT-1:0]       slotVld_q, slotVld_d;
  logic [1:0]               slotUnit_q [MAX_LAT];
  logic [1:0]               slotUnit_d [MAX_LAT];
  logic [ADDRESS_WIDTH-1:0] slotAddr_q [MAX_LAT];
  logic [ADDRESS_WIDTH-1:0] slotAddr_d [MAX_LAT];
  logic                     issErr_q;
  logic [15:0]              stallCnt_q;

  logic [MAX_LAT:0]         vldExt;
  logic                     issLegal;
  int                       issLat;
  logic                     portConflict;
  logic                     rawHit;
  logic                     wawHit;
  logic                     bcSlotHit;
  logic                     bcGnt;
  logic                     bcRaw;
  logic                     issRdy;
  logic                     issAccept;
  logic [SIGNAL_WIDTH-1:0]  cuEn;

  // Extra always-empty entry on top so the shift reads slot[D] as empty.
  assign vldExt = {1'b0, slotVld_q};

  always_comb begin
    issLegal = 1'b1;
    issLat   = 0;
    case (bus.iss_unit)
      UNIT_ALU: issLat = ALU_LAT;
      UNIT_MUL: issLat = MUL_LAT;
      UNIT_SHF: issLat = SHF_LAT;
      default:  issLegal = 1'b0;
    endcase
  end

  // A new result lands in slot[L-1] after the shift, which is where slot[L]
  // moves to, so an occupied slot[L] is a write-port conflict.
  always_comb begin
    portConflict = 1'b0;
    rawHit       = 1'b0;
    wawHit       = 1'b0;
    bcSlotHit    = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (slotVld_q[k]) begin
        if (issLat == k) portConflict = 1'b1;
        if (bus.iss_rx_use && (bus.iss_raddx == slotAddr_q[k])) rawHit = 1'b1;
        if (bus.iss_ry_use && (bus.iss_raddy == slotAddr_q[k])) rawHit = 1'b1;
        if (bus.iss_wadd == slotAddr_q[k]) wawHit = 1'b1;
        if (bus.bc_wadd == slotAddr_q[k]) bcSlotHit = 1'b1;
      end
    end
  end

  // Bus-connect only gets the write port in cycles without a CU write-back,
  // and never to a register that still has a result in flight.
  assign bcGnt = bus.bc_req & ~slotVld_q[0] & ~bcSlotHit;
  assign bcRaw = bcGnt & ((bus.iss_rx_use & (bus.iss_raddx == bus.bc_wadd)) |
                          (bus.iss_ry_use & (bus.iss_raddy == bus.bc_wadd)));

  // Illegal unit codes are swallowed immediately so the sequencer never hangs.
  assign issRdy    = ~issLegal | ~(portConflict | rawHit | wawHit | bcRaw);
  assign issAccept = bus.iss_vld & issRdy;

  always_comb begin
    slotVld_d  = vldExt[MAX_LAT:1];
    slotUnit_d = '{default: '0};
    slotAddr_d = '{default: '0};
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      slotUnit_d[k] = slotUnit_q[k+1];
      slotAddr_d[k] = slotAddr_q[k+1];
    end
    if (issAccept && issLegal) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        if (issLat == k + 1) begin
          slotVld_d[k]  = 1'b1;
          slotUnit_d[k] = bus.iss_unit;
          slotAddr_d[k] = bus.iss_wadd;
        end
      end
    end
  end

  always_comb begin
    cuEn = '0;
    if (slotVld_q[0]) begin
      case (slotUnit_q[0])
        UNIT_ALU: cuEn[0] = 1'b1;
        UNIT_MUL: cuEn[1] = 1'b1;
        UNIT_SHF: cuEn[2] = 1'b1;
        default:  cuEn    = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slotVld_q  <= '0;
      slotUnit_q <= '{default: '0};
      slotAddr_q <= '{default: '0};
      issErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      slotVld_q  <= slotVld_d;
      slotUnit_q <= slotUnit_d;
      slotAddr_q <= slotAddr_d;
      issErr_q   <= issAccept & ~issLegal;
      if (bus.iss_vld && !issRdy && (stallCnt_q != 16'hFFFF)) begin
        stallCnt_q <= stallCnt_q + 16'd1;
      end
    end
  end

  assign bus.iss_rdy      = issRdy;
  assign bus.iss_err      = issErr_q;
  assign bus.ps_alu_en    = issAccept & (bus.iss_unit == UNIT_ALU);
  assign bus.ps_mul_en    = issAccept & (bus.iss_unit == UNIT_MUL);
  assign bus.ps_shf_en    = issAccept & (bus.iss_unit == UNIT_SHF);
  assign bus.ps_xb_raddx  = bus.iss_raddx;
  assign bus.ps_xb_raddy  = bus.iss_raddy;
  assign bus.ps_xb_w_cuEn = cuEn;
  assign bus.ps_xb_w_bcEn = bcGnt;
  assign bus.ps_xb_wadd   = slotVld_q[0] ? slotAddr_q[0] : bus.bc_wadd;
  assign bus.bc_gnt       = bcGnt;
  assign bus.busy         = |slotVld_q;
  assign bus.stall_cnt    = stallCnt_q;

endmodule

// File: tb/tb_cu_wb_sched.sv
// tb_cu_wb_sched
//   Directed bench for cu_wb_sched: issue timing, port conflicts, RAW/WAW
//   stalls, bus-connect arbitration, illegal ops, mid-flight reset and
//   stall counter saturation. Expected values are hand-computed.
module tb_cu_wb_sched;

  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] MUL = 2'b01;
  localparam logic [1:0] SHF = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  cu_wb_sched_if #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) busIf ();

  cu_wb_sched #(
    .ADDRESS_WIDTH(4),
    .SIGNAL_WIDTH (3),
    .ALU_LAT      (1),
    .MUL_LAT      (2),
    .SHF_LAT      (1),
    .MAX_LAT      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (busIf)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge so outputs can be sampled for that cycle.
  task automatic applyStimulus(input logic vld, input logic [1:0] unit,
                               input logic rxUse, input logic ryUse,
                               input logic [3:0] raddx, input logic [3:0] raddy,
                               input logic [3:0] wadd,
                               input logic bcReq, input logic [3:0] bcWadd);
    @(posedge clk);
    #1;
    busIf.iss_vld    = vld;
    busIf.iss_unit   = unit;
    busIf.iss_rx_use = rxUse;
    busIf.iss_ry_use = ryUse;
    busIf.iss_raddx  = raddx;
    busIf.iss_raddy  = raddy;
    busIf.iss_wadd   = wadd;
    busIf.bc_req     = bcReq;
    busIf.bc_wadd    = bcWadd;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, ALU, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset            = 1'b0;
    busIf.iss_vld    = 1'b0;
    busIf.iss_unit   = ALU;
    busIf.iss_rx_use = 1'b0;
    busIf.iss_ry_use = 1'b0;
    busIf.iss_raddx  = 4'd0;
    busIf.iss_raddy  = 4'd0;
    busIf.iss_wadd   = 4'd0;
    busIf.bc_req     = 1'b0;
    busIf.bc_wadd    = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_rdy",   32'(busIf.iss_rdy), 32'd1);
    checkOutput("rst_busy",  32'(busIf.busy), 32'd0);
    checkOutput("rst_cuEn",  32'(busIf.ps_xb_w_cuEn), 32'd0);
    checkOutput("rst_bcEn",  32'(busIf.ps_xb_w_bcEn), 32'd0);
    checkOutput("rst_err",   32'(busIf.iss_err), 32'd0);
    checkOutput("rst_stall", 32'(busIf.stall_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: single ALU op, write-back one cycle later
    applyStimulus(1'b1, ALU, 1'b0, 1'b0, 4'd2, 4'd9, 4'd3, 1'b0, 4'd0);
    checkOutput("t1_rdy",    32'(busIf.iss_rdy), 32'd1);
    checkOutput("t1_aluEn",  32'(busIf.ps_alu_en), 32'd1);
    checkOutput("t1_mulEn",  32'(busIf.ps_mul_en), 32'd0);
    checkOutput("t1_shfEn",  32'(busIf.ps_shf_en), 32'd0);
    checkOutput("t1_raddx",  32'(busIf.ps_xb_raddx), 32'd2);
    checkOutput("t1_raddy",  32'(busIf.ps_xb_raddy), 32'd9);
    checkOutput("t1_cuEnC0", 32'(busIf.ps_xb_w_cuEn), 32'd0);
    idleCycle();
    checkOutput("t1_cuEnC1", 32'(busIf.ps_xb_w_cuEn), 32'b001);
    checkOutput("t1_waddC1", 32'(busIf.ps_xb_wadd), 32'd3);
    checkOutput("t1_busyC1", 32'(busIf.busy), 32'd1);
    checkOutput("t1_aluOff", 32'(busIf.ps_alu_en), 32'd0);
    idleCycle();
    checkOutput("t1_busyC2", 32'(busIf.busy), 32'd0);
    checkOutput("t1_cuEnC2", 32'(busIf.ps_xb_w_cuEn), 32'd0);

    // 2: MUL then ALU collide on the write port
    applyStimulus(1'b1, MUL, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 1'b0, 4'd0);
    checkOutput("t2_mulEn",  32'(busIf.ps_mul_en), 32'd1);
    applyStimulus(1'b1, ALU, 1'b0, 1'b0, 4'd0, 4'd0, 4'd6, 1'b0, 4'd0);
    checkOutput("t2_rdyC1",  32'(busIf.iss_rdy), 32'd0);
    checkOutput("t2_aluC1",  32'(busIf.ps_alu_en), 32'd0);
    checkOutput("t2_cuEnC1", 32'(busIf.ps_xb_w_cuEn), 32'd0);
    applyStimulus(1'b1, ALU, 1'b0, 1'b0, 4'd0, 4'd0, 4'd6, 1'b0, 4'd0);
    checkOutput("t2_rdyC2",  32'(busIf.iss_rdy), 32'd1);
    checkOutput("t2_aluC2",  32'(busIf.ps_alu_en), 32'd1);
    checkOutput("t2_cuEnC2", 32'(busIf.ps_xb_w_cuEn), 32'b010);
    checkOutput("t2_waddC2", 32'(busIf.ps_xb_wadd), 32'd5);
    idleCycle();
    checkOutput("t2_cuEnC3", 32'(busIf.ps_xb_w_cuEn), 32'b001);
    checkOutput("t2_waddC3", 32'(busIf.ps_xb_wadd), 32'd6);
    checkOutput("t2_stall",  32'(busIf.stall_cnt), 32'd1);
    idleCycle();
    checkOutput("t2_busyC4", 32'(busIf.busy), 32'd0);

    // 3: RAW on an in-flight MUL result
    applyStimulus(1'b1, MUL, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, 1'b0, 4'd0);
    checkOutput("t3_mulEn",  32'(busIf.ps_mul_en), 32'd1);
    applyStimulus(1'b1, ALU, 1'b1, 1'b0, 4'd4, 4'd0, 4'd8, 1'b0, 4'd0);
    checkOutput("t3_rdyC1",  32'(busIf.iss_rdy), 32'd0);
    applyStimulus(1'b1, ALU, 1'b1, 1'b0, 4'd4, 4'd0, 4'd8, 1'b0, 4'd0);
    checkOutput("t3_rdyC2",  32'(busIf.iss_rdy), 32'd0);
    checkOutput("t3_cuEnC2", 32'(busIf.ps_xb_w_cuEn), 32'b010);
    checkOutput("t3_waddC2", 32'(busIf.ps_xb_wadd), 32'd4);
    applyStimulus(1'b1, ALU, 1'b1, 1'b0, 4'd4, 4'd0, 4'd8, 1'b0, 4'd0);
    checkOutput("t3_rdyC3",  32'(busIf.iss_rdy), 32'd1);
    checkOutput("t3_aluC3",  32'(busIf.ps_alu_en), 32'd1);
    idleCycle();
    checkOutput("t3_cuEnC4", 32'(busIf.ps_xb_w_cuEn), 32'b001);
    checkOutput("t3_waddC4", 32'(busIf.ps_xb_wadd), 32'd8);
    checkOutput("t3_stall",  32'(busIf.stall_cnt), 32'd3);

    // 4: bus-connect waits for a free slot; WAW and bc RAW stall issue
    applyStimulus(1'b1, ALU, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 1'b0, 4'd0);
    checkOutput("t4_aluC0",  32'(busIf.ps_alu_en), 32'd1);
    applyStimulus(1'b1, ALU, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 1'b1, 4'd7);
    checkOutput("t4_wawRdy", 32'(busIf.iss_rdy), 32'd0);
    checkOutput("t4_gntC1",  32'(busIf.bc_gnt), 32'd0);
    checkOutput("t4_bcEnC1", 32'(busIf.ps_xb_w_bcEn), 32'd0);
    checkOutput("t4_waddC1", 32'(busIf.ps_xb_wadd), 32'd9);
    applyStimulus(1'b1, ALU, 1'b1, 1'b0, 4'd7, 4'd0, 4'd10, 1'b1, 4'd7);
    checkOutput("t4_gntC2",  32'(busIf.bc_gnt), 32'd1);
    checkOutput("t4_bcEnC2", 32'(busIf.ps_xb_w_bcEn), 32'd1);
    checkOutput("t4_waddC2", 32'(busIf.ps_xb_wadd), 32'd7);
    checkOutput("t4_rdyC2",  32'(busIf.iss_rdy), 32'd0);
    checkOutput("t4_aluC2",  32'(busIf.ps_alu_en), 32'd0);
    idleCycle();
    checkOutput("t4_gntC3",  32'(busIf.bc_gnt), 32'd0);
    checkOutput("t4_stall",  32'(busIf.stall_cnt), 32'd5);

    // 5a: illegal unit code
    applyStimulus(1'b1, ILL, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 4'd0);
    checkOutput("t5_rdy",    32'(busIf.iss_rdy), 32'd1);
    checkOutput("t5_enables",
                32'({busIf.ps_alu_en, busIf.ps_mul_en, busIf.ps_shf_en}), 32'd0);
    checkOutput("t5_errC0",  32'(busIf.iss_err), 32'd0);
    idleCycle();
    checkOutput("t5_errC1",  32'(busIf.iss_err), 32'd1);
    checkOutput("t5_busyC1", 32'(busIf.busy), 32'd0);
    idleCycle();
    checkOutput("t5_errC2",  32'(busIf.iss_err), 32'd0);

    // 5b: reset with a MUL in flight drops the result
    applyStimulus(1'b1, MUL, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 4'd0);
    checkOutput("t5_mulEn",  32'(busIf.ps_mul_en), 32'd1);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    busIf.iss_vld = 1'b0;
    #1;
    checkOutput("t5_rstBusy",  32'(busIf.busy), 32'd0);
    checkOutput("t5_rstStall", 32'(busIf.stall_cnt), 32'd0);
    @(negedge clk);
    checkOutput("t5_rstRdy",   32'(busIf.iss_rdy), 32'd1);
    checkOutput("t5_rstCuEn",  32'(busIf.ps_xb_w_cuEn), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("t5_postCuEn", 32'(busIf.ps_xb_w_cuEn), 32'd0);
    end
    checkOutput("t5_postBusy", 32'(busIf.busy), 32'd0);

    // 6: persistent bc RAW stall drives stall_cnt into saturation
    applyStimulus(1'b1, SHF, 1'b1, 1'b0, 4'd12, 4'd0, 4'd13, 1'b1, 4'd12);
    checkOutput("t6_rdy",    32'(busIf.iss_rdy), 32'd0);
    checkOutput("t6_shfEn",  32'(busIf.ps_shf_en), 32'd0);
    checkOutput("t6_gnt",    32'(busIf.bc_gnt), 32'd1);
    checkOutput("t6_cnt0",   32'(busIf.stall_cnt), 32'd0);
    repeat (100) @(negedge clk);
    checkOutput("t6_cnt100", 32'(busIf.stall_cnt), 32'd100);
    repeat (65434) @(negedge clk);
    checkOutput("t6_cntFFFE", 32'(busIf.stall_cnt), 32'hFFFE);
    repeat (1) @(negedge clk);
    checkOutput("t6_cntFFFF", 32'(busIf.stall_cnt), 32'hFFFF);
    repeat (10) @(negedge clk);
    checkOutput("t6_cntSat", 32'(busIf.stall_cnt), 32'hFFFF);
    idleCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
